cmul_stream_rnd_sat: RTL and testbench
======================================

Name: cmul_stream_rnd_sat

Overview:
- Parametrised, fully handshaked complex multiplier with integrated round, shift and saturate.
- Joins two AXI-stream complex sample streams and multiplies them, optionally conjugating B.
- Scales the full-precision product by a per-sample right shift, rounds it, and saturates it to OUT_WIDTH.
- Used in DSP datapaths (mixers, channel correction), replacing fixed 16-bit multiply-plus-separate-clip chains.

Parameters:
- WIDTH, 16, bit width of each I and Q component on A and B inputs (two's complement).
- OUT_WIDTH, 16, bit width of each I and Q component on the output.
- SHIFT_WIDTH, 6, width of the runtime shift input; shift values above 2*WIDTH are treated as 2*WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- a_tdata  in  2*WIDTH  {I,Q}, I in the upper half.
- a_tlast  in  1  end of packet, propagated to o_tlast.
- a_tvalid  in  1  A beat valid.
- a_tready  out  1  A beat accepted.
- b_tdata  in  2*WIDTH  {I,Q}, I in the upper half.
- b_tlast  in  1  ignored.
- b_tvalid  in  1  B beat valid.
- b_tready  out  1  B beat accepted.
- conj  in  1  1 = multiply by conj(B); sampled with each accepted beat.
- shift  in  SHIFT_WIDTH  right-shift amount; sampled with each accepted beat.
- o_tdata  out  2*OUT_WIDTH  {I,Q} result.
- o_tlast  out  1  end of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.
- o_sat  out  1  1 if I or Q saturated on this beat; qualified by o_tvalid.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valid bits clear; o_tvalid=0, o_tlast=0, o_sat=0, o_tdata=0, a_tready=b_tready=0. Outputs stay at these values until the first clk edge after reset release.
- Reset asserted mid-operation discards all in-flight beats. No output is produced for them after release.
- Pipeline enable: en = !o_tvalid || o_tready. The whole pipeline stalls when en=0. Data and valid bits hold. No beat is dropped or duplicated.
- Join: a_tready = b_tready = a_tvalid && b_tvalid && en. A beat is accepted only when both inputs are valid and en=1, so A and B are consumed together.
  - If one input is valid alone, nothing is consumed.
  - Each ready never depends on its own valid alone.
- Pipeline: 4 stages, fixed.
  - S1 registers A, B, conj, shift and a_tlast.
  - S2 forms the four signed products, 2*WIDTH bits each.
  - S3 forms the sums, 2*WIDTH+1 bits.
  - S4 does round/shift/saturate and drives the output registers.
- Latency: an accepted beat appears on o_tdata with o_tvalid=1 at the 4th rising edge after acceptance, provided no stall occurs. Throughput is 1 beat/cycle when o_tready=1.
- Arithmetic:
  - conj=0: I = aI*bI - aQ*bQ; Q = aI*bQ + aQ*bI.
  - conj=1: I = aI*bI + aQ*bQ; Q = aQ*bI - aI*bQ.
  - Sums are exact and never wrap. The full-scale case (-2^(WIDTH-1))^2 * 2 fits in 2*WIDTH+1 bits.
- Rounding: s = min(shift, 2*WIDTH).
  - If s>0: r = (x + 2^(s-1)) >>> s (round half up, arithmetic shift).
  - If s=0: r = x.
  - The rounding addition is computed in 2*WIDTH+2 bits, so it cannot overflow.
- Saturation:
  - If r > 2^(OUT_WIDTH-1)-1, output 2^(OUT_WIDTH-1)-1.
  - If r < -2^(OUT_WIDTH-1), output -2^(OUT_WIDTH-1).
  - o_sat = OR of the I and Q saturation events for that beat.
- Per-sample config: conj and shift travel with their beat. Changing them between consecutive beats affects only later beats, with no bubble.
- o_tlast = a_tlast of the same beat; b_tlast is not used.
- Simultaneous output accept and input accept in one cycle (full pipeline, o_tready=1): both occur, and occupancy is unchanged.
- Output not valid (pipeline draining): o_tdata is don't-care. The verifier checks o_tdata only when o_tvalid=1.

Test Plan:
- Basic product (WIDTH=OUT_WIDTH=16): a=(0x4000,0), b=(0x4000,0), shift=15, conj=0 -> o_tdata=(0x2000,0x0000), o_sat=0, o_tvalid 4 cycles after accept.
- Conjugate: a=(0,0x4000), b=(0,0x4000), shift=15. conj=0 -> (0xE000,0x0000); conj=1 -> (0x2000,0x0000). Both sent back-to-back, and each beat uses its own conj.
- Saturation: a=b=(0x8000,0x8000), shift=15 -> I=0x0000, Q=0x7FFF, o_sat=1. With shift=17: Q=0x4000, o_sat=0.
- Rounding: a=(1,0), b=(0x4000,0), shift=15 -> I=0x0001. a=(0xFFFF,0), same b and shift -> I=0x0000. a=(3,0), b=(0x4000,0), shift=15 -> I=0x0002.
- Backpressure/join: 20-beat random stream with independent random a_tvalid, b_tvalid and o_tready -> output sequence equals the reference model in order; no drop or duplicate; a_tready==b_tready at all times; a_tlast on beat 20 appears only on output beat 20.
- Reset mid-stream: assert reset=0 with 3 beats in flight, release, send 1 new beat -> only that beat is output; all outputs are 0 during reset.

Source files
------------

// File: rtl/cmul_stream_rnd_sat.sv
// cmul_stream_rnd_sat: complex multiplier for two joined AXI-stream sample streams.
// It can conjugate B, then applies a per-beat rounded right shift and saturation.
// There are four fixed register stages:
//   S1 input capture, S2 products, S3 sums, S4 round/shift/saturate.
// A single enable stalls the whole pipeline under output backpressure.
module cmul_stream_rnd_sat #(
    parameter int WIDTH       = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2*WIDTH-1:0]       a_tdata,
    input  logic                     a_tlast,
    input  logic                     a_tvalid,
    output logic                     a_tready,
    input  logic [2*WIDTH-1:0]       b_tdata,
    input  logic                     b_tlast,
    input  logic                     b_tvalid,
    output logic                     b_tready,
    input  logic                     conj,
    input  logic [SHIFT_WIDTH-1:0]   shift,
    output logic [2*OUT_WIDTH-1:0]   o_tdata,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     o_sat
);

    localparam int PW = 2 * WIDTH;
    localparam int XW = PW + 1;
    localparam int RW = PW + 2;
    localparam logic [31:0] SMAX = 32'(PW);
    localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // B's tlast carries no meaning here; packet framing comes from A.
    logic unused_b_tlast;
    assign unused_b_tlast = b_tlast;

    // Handshake and pipeline state.
    logic                    en;
    logic                    accept;
    logic                    run_q, run_d;

    logic                    v1_q, v1_d;
    logic [PW-1:0]           a1_q, a1_d;
    logic [PW-1:0]           b1_q, b1_d;
    logic                    conj1_q, conj1_d;
    logic [SHIFT_WIDTH-1:0]  shift1_q, shift1_d;
    logic                    last1_q, last1_d;

    logic                    v2_q, v2_d;
    logic signed [PW-1:0]    p_ii_q, p_ii_d;
    logic signed [PW-1:0]    p_qq_q, p_qq_d;
    logic signed [PW-1:0]    p_iq_q, p_iq_d;
    logic signed [PW-1:0]    p_qi_q, p_qi_d;
    logic                    conj2_q, conj2_d;
    logic [SHIFT_WIDTH-1:0]  shift2_q, shift2_d;
    logic                    last2_q, last2_d;

    logic                    v3_q, v3_d;
    logic signed [XW-1:0]    x_i_q, x_i_d;
    logic signed [XW-1:0]    x_q_q, x_q_d;
    logic [SHIFT_WIDTH-1:0]  shift3_q, shift3_d;
    logic                    last3_q, last3_d;

    logic                    o_tvalid_q, o_tvalid_d;
    logic [2*OUT_WIDTH-1:0]  o_tdata_q, o_tdata_d;
    logic                    o_tlast_q, o_tlast_d;
    logic                    o_sat_q, o_sat_d;

    // Rounds x by 2^s (round half up), then clamps it to OUT_WIDTH; the top bit returned is the saturation flag.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [XW-1:0] x,
                                                     input logic [31:0] s);
        logic signed [RW-1:0] xe;
        logic signed [RW-1:0] rnd;
        logic signed [RW-1:0] r;
        logic [OUT_WIDTH:0]   res;
        xe  = {x[XW-1], x};
        rnd = '0;
        if (s != 32'd0) begin
            rnd = {{(RW-1){1'b0}}, 1'b1} << (s - 32'd1);
        end
        r = (xe + rnd) >>> s;
        if (r > OMAX) begin
            res = {1'b1, OMAX[OUT_WIDTH-1:0]};
        end else if (r < OMIN) begin
            res = {1'b1, OMIN[OUT_WIDTH-1:0]};
        end else begin
            res = {1'b0, r[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    // Join: both streams are consumed together and only while the pipeline can advance.
    // run_q holds ready low until the first clock edge after reset release.
    always_comb begin
        en     = !o_tvalid_q || o_tready;
        accept = run_q && a_tvalid && b_tvalid && en;
        run_d  = 1'b1;
    end

    assign a_tready = accept;
    assign b_tready = accept;

    // S1 captures the joined beat together with its own conj, shift and tlast.
    always_comb begin
        v1_d     = v1_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        conj1_d  = conj1_q;
        shift1_d = shift1_q;
        last1_d  = last1_q;
        if (en) begin
            v1_d     = accept;
            a1_d     = a_tdata;
            b1_d     = b_tdata;
            conj1_d  = conj;
            shift1_d = shift;
            last1_d  = a_tlast;
        end
    end

    // S2 forms the four signed cross products at full precision.
    always_comb begin
        logic signed [PW-1:0] ai, aq, bi, bq;
        ai = {{WIDTH{a1_q[PW-1]}},    a1_q[PW-1:WIDTH]};
        aq = {{WIDTH{a1_q[WIDTH-1]}}, a1_q[WIDTH-1:0]};
        bi = {{WIDTH{b1_q[PW-1]}},    b1_q[PW-1:WIDTH]};
        bq = {{WIDTH{b1_q[WIDTH-1]}}, b1_q[WIDTH-1:0]};
        v2_d     = v2_q;
        p_ii_d   = p_ii_q;
        p_qq_d   = p_qq_q;
        p_iq_d   = p_iq_q;
        p_qi_d   = p_qi_q;
        conj2_d  = conj2_q;
        shift2_d = shift2_q;
        last2_d  = last2_q;
        if (en) begin
            v2_d     = v1_q;
            p_ii_d   = ai * bi;
            p_qq_d   = aq * bq;
            p_iq_d   = ai * bq;
            p_qi_d   = aq * bi;
            conj2_d  = conj1_q;
            shift2_d = shift1_q;
            last2_d  = last1_q;
        end
    end

    // S3 combines the products one bit wider, so even the full-scale case cannot wrap.
    always_comb begin
        logic signed [XW-1:0] ii, qq, iq, qi;
        ii = {p_ii_q[PW-1], p_ii_q};
        qq = {p_qq_q[PW-1], p_qq_q};
        iq = {p_iq_q[PW-1], p_iq_q};
        qi = {p_qi_q[PW-1], p_qi_q};
        v3_d     = v3_q;
        x_i_d    = x_i_q;
        x_q_d    = x_q_q;
        shift3_d = shift3_q;
        last3_d  = last3_q;
        if (en) begin
            v3_d     = v2_q;
            x_i_d    = conj2_q ? (ii + qq) : (ii - qq);
            x_q_d    = conj2_q ? (qi - iq) : (iq + qi);
            shift3_d = shift2_q;
            last3_d  = last2_q;
        end
    end

    // S4 clamps the shift, rounds and saturates both components, and loads the output registers.
    always_comb begin
        logic [31:0]        s_ext;
        logic [31:0]        s_amt;
        logic [OUT_WIDTH:0] ri;
        logic [OUT_WIDTH:0] rq;
        s_ext = {{(32-SHIFT_WIDTH){1'b0}}, shift3_q};
        s_amt = (s_ext > SMAX) ? SMAX : s_ext;
        ri    = round_sat(x_i_q, s_amt);
        rq    = round_sat(x_q_q, s_amt);
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_sat_d    = o_sat_q;
        if (en) begin
            o_tvalid_d = v3_q;
            o_tdata_d  = {ri[OUT_WIDTH-1:0], rq[OUT_WIDTH-1:0]};
            o_tlast_d  = last3_q;
            o_sat_d    = ri[OUT_WIDTH] | rq[OUT_WIDTH];
        end
    end

    // All pipeline state; reset drops every in-flight beat and clears the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            v1_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            conj1_q    <= 1'b0;
            shift1_q   <= '0;
            last1_q    <= 1'b0;
            v2_q       <= 1'b0;
            p_ii_q     <= '0;
            p_qq_q     <= '0;
            p_iq_q     <= '0;
            p_qi_q     <= '0;
            conj2_q    <= 1'b0;
            shift2_q   <= '0;
            last2_q    <= 1'b0;
            v3_q       <= 1'b0;
            x_i_q      <= '0;
            x_q_q      <= '0;
            shift3_q   <= '0;
            last3_q    <= 1'b0;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_sat_q    <= 1'b0;
        end else begin
            run_q      <= run_d;
            v1_q       <= v1_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            conj1_q    <= conj1_d;
            shift1_q   <= shift1_d;
            last1_q    <= last1_d;
            v2_q       <= v2_d;
            p_ii_q     <= p_ii_d;
            p_qq_q     <= p_qq_d;
            p_iq_q     <= p_iq_d;
            p_qi_q     <= p_qi_d;
            conj2_q    <= conj2_d;
            shift2_q   <= shift2_d;
            last2_q    <= last2_d;
            v3_q       <= v3_d;
            x_i_q      <= x_i_d;
            x_q_q      <= x_q_d;
            shift3_q   <= shift3_d;
            last3_q    <= last3_d;
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_sat_q    <= o_sat_d;
        end
    end

    assign o_tvalid = o_tvalid_q;
    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_sat    = o_sat_q;

endmodule

// File: tb/tb_cmul_stream_rnd_sat.sv
// Testbench for cmul_stream_rnd_sat (defaults WIDTH=OUT_WIDTH=16, SHIFT_WIDTH=6).
// It uses a table of hand-computed vectors, a random backpressure stream checked against a behavioural
// model, and hand-written latency and mid-stream reset sequences.
// Expected beats are queued when a beat is accepted and compared when it comes out.
module tb_cmul_stream_rnd_sat;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_tdata;
    logic        a_tlast;
    logic        a_tvalid;
    logic        a_tready;
    logic [31:0] b_tdata;
    logic        b_tlast;
    logic        b_tvalid;
    logic        b_tready;
    logic        conj;
    logic [5:0]  shift;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_sat;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cj;
        logic [5:0]  sh;
        logic        last;
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        sat;
        logic        last;
    } exp_t;

    vec_t vecs[12];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;

    cmul_stream_rnd_sat dut (
        .clk      (clk),
        .reset    (reset),
        .a_tdata  (a_tdata),
        .a_tlast  (a_tlast),
        .a_tvalid (a_tvalid),
        .a_tready (a_tready),
        .b_tdata  (b_tdata),
        .b_tlast  (b_tlast),
        .b_tvalid (b_tvalid),
        .b_tready (b_tready),
        .conj     (conj),
        .shift    (shift),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_sat    (o_sat)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cj, input logic [5:0] sh, input logic last);
        logic signed [15:0] t;
        longint ai, aq, bi, bq, xi, xq;
        int s;
        exp_t e;
        t = a[31:16]; ai = t;
        t = a[15:0];  aq = t;
        t = b[31:16]; bi = t;
        t = b[15:0];  bq = t;
        if (cj) begin
            xi = ai * bi + aq * bq;
            xq = aq * bi - ai * bq;
        end else begin
            xi = ai * bi - aq * bq;
            xq = ai * bq + aq * bi;
        end
        s = (sh > 6'd32) ? 32 : int'(sh);
        if (s > 0) begin
            xi = (xi + (longint'(1) <<< (s - 1))) >>> s;
            xq = (xq + (longint'(1) <<< (s - 1))) >>> s;
        end
        e.sat = 1'b0;
        if (xi > 32767)  begin xi = 32767;  e.sat = 1'b1; end
        if (xi < -32768) begin xi = -32768; e.sat = 1'b1; end
        if (xq > 32767)  begin xq = 32767;  e.sat = 1'b1; end
        if (xq < -32768) begin xq = -32768; e.sat = 1'b1; end
        e.data = {xi[15:0], xq[15:0]};
        e.last = last;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output actual=%0h expected=none", o_tdata);
        end else begin
            e = exp_q.pop_front();
            check("o_tdata", {32'd0, o_tdata}, {32'd0, e.data});
            check("o_sat", {63'd0, o_sat}, {63'd0, e.sat});
            check("o_tlast", {63'd0, o_tlast}, {63'd0, e.last});
            out_count++;
        end
    endtask

    // Drives one cycle at the falling edge and samples #1 later, before the next rising edge acts.
    task automatic apply_stimulus(input logic av, input logic bv, input logic [31:0] a,
                                  input logic [31:0] b, input logic cj, input logic [5:0] sh,
                                  input logic lst, input logic ordy, output logic accepted);
        @(negedge clk);
        a_tvalid = av;
        b_tvalid = bv;
        a_tdata  = a;
        b_tdata  = b;
        conj     = cj;
        shift    = sh;
        a_tlast  = lst;
        b_tlast  = ~lst;
        o_tready = ordy;
        #1;
        check("ready_eq", {63'd0, a_tready}, {63'd0, b_tready});
        check("join_rule", {63'd0, a_tready && !(av && bv && (!o_tvalid || ordy))}, 64'd0);
        accepted = av && bv && a_tready;
        if (o_tvalid && o_tready) check_output();
    endtask

    task automatic idle_cycle(input logic ordy);
        logic acc;
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 6'd0, 1'b0, ordy, acc);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic cj,
                             input logic [5:0] sh, input logic lst, input exp_t e);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            apply_stimulus(1'b1, 1'b1, a, b, cj, sh, lst, 1'b1, acc);
            if (acc) exp_q.push_back(e);
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int budget, input bit random_ready);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            idle_cycle(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_zero();
        check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
        check("rst_o_tdata", {32'd0, o_tdata}, 64'd0);
        check("rst_o_sat_tlast", {62'd0, o_sat, o_tlast}, 64'd0);
        check("rst_ready", {62'd0, a_tready, b_tready}, 64'd0);
    endtask

    initial begin
        exp_t e;
        logic acc;
        int n, base, k, cyc;
        logic [31:0] ra[20];
        logic [31:0] rb[20];
        logic        rc[20];
        logic [5:0]  rs[20];

        vecs[0]  = '{32'h4000_0000, 32'h4000_0000, 1'b0, 6'd15, 1'b0, 32'h2000_0000, 1'b0};
        vecs[1]  = '{32'h0000_4000, 32'h0000_4000, 1'b0, 6'd15, 1'b0, 32'hE000_0000, 1'b0};
        vecs[2]  = '{32'h0000_4000, 32'h0000_4000, 1'b1, 6'd15, 1'b0, 32'h2000_0000, 1'b0};
        vecs[3]  = '{32'h8000_8000, 32'h8000_8000, 1'b0, 6'd15, 1'b0, 32'h0000_7FFF, 1'b1};
        vecs[4]  = '{32'h8000_8000, 32'h8000_8000, 1'b0, 6'd17, 1'b0, 32'h0000_4000, 1'b0};
        vecs[5]  = '{32'h0001_0000, 32'h4000_0000, 1'b0, 6'd15, 1'b0, 32'h0001_0000, 1'b0};
        vecs[6]  = '{32'hFFFF_0000, 32'h4000_0000, 1'b0, 6'd15, 1'b0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{32'h0003_0000, 32'h4000_0000, 1'b0, 6'd15, 1'b0, 32'h0002_0000, 1'b0};
        vecs[8]  = '{32'h8000_8000, 32'h8000_8000, 1'b0, 6'd63, 1'b0, 32'h0000_0001, 1'b0};
        vecs[9]  = '{32'h7FFF_0000, 32'h8000_0000, 1'b0, 6'd0,  1'b0, 32'h8000_0000, 1'b1};
        vecs[10] = '{32'h0003_0005, 32'h0007_0002, 1'b1, 6'd0,  1'b0, 32'h001F_001D, 1'b0};
        vecs[11] = '{32'h0003_0005, 32'h0007_0002, 1'b0, 6'd0,  1'b1, 32'h000B_0029, 1'b0};

        reset    = 1'b0;
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        a_tdata  = 32'h1234_5678;
        b_tdata  = 32'h1234_5678;
        a_tlast  = 1'b1;
        b_tlast  = 1'b0;
        conj     = 1'b0;
        shift    = 6'd0;
        o_tready = 1'b1;
        #12;
        $display("[TB] reset state");
        check_reset_zero();
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] latency of a single beat");
        e = '{vecs[0].exp_data, vecs[0].exp_sat, vecs[0].last};
        send_beat(vecs[0].a, vecs[0].b, vecs[0].cj, vecs[0].sh, vecs[0].last, e);
        base = out_count;
        n = 0;
        while (out_count == base && n < 10) begin
            n++;
            idle_cycle(1'b1);
        end
        check("latency", 64'(n), 64'd4);

        $display("[TB] vector table back-to-back");
        for (int i = 1; i < 12; i++) begin
            e = '{vecs[i].exp_data, vecs[i].exp_sat, vecs[i].last};
            send_beat(vecs[i].a, vecs[i].b, vecs[i].cj, vecs[i].sh, vecs[i].last, e);
        end
        drain(30, 1'b0);
        check("table_out_count", 64'(out_count), 64'd12);

        $display("[TB] random stream with backpressure");
        for (int i = 0; i < 20; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 6'($urandom_range(10, 20));
        end
        base = out_count;
        k = 0;
        cyc = 0;
        while (k < 20 && cyc < 400) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                           ra[k], rb[k], rc[k], rs[k], k == 19,
                           1'($urandom_range(0, 2) != 0), acc);
            if (acc) begin
                exp_q.push_back(model(ra[k], rb[k], rc[k], rs[k], k == 19));
                k++;
            end
            cyc++;
        end
        check("random_accepted", 64'(k), 64'd20);
        drain(300, 1'b1);
        check("random_out_count", 64'(out_count - base), 64'd20);

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            e = '{vecs[3].exp_data, vecs[3].exp_sat, 1'b0};
            send_beat(vecs[3].a, vecs[3].b, vecs[3].cj, vecs[3].sh, 1'b0, e);
        end
        @(negedge clk);
        reset    = 1'b0;
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        o_tready = 1'b1;
        #1;
        check_reset_zero();
        exp_q.delete();
        @(negedge clk);
        #1;
        check_reset_zero();
        @(negedge clk);
        reset = 1'b1;
        base = out_count;
        e = '{vecs[7].exp_data, vecs[7].exp_sat, 1'b1};
        send_beat(vecs[7].a, vecs[7].b, vecs[7].cj, vecs[7].sh, 1'b1, e);
        drain(20, 1'b0);
        for (int i = 0; i < 6; i++) idle_cycle(1'b1);
        check("post_reset_out_count", 64'(out_count - base), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
